// File: rtl/text_buffer_if.sv
// text_buffer_if: glyph write handshake, commands, display read port and RAM port of the text buffer controller
interface text_buffer_if #(parameter int ADDR_W = 13, parameter int CODE_W = 5);
  logic wr_valid;
  logic [CODE_W-1:0] wr_code;
  logic wr_ready;
  logic cmd_clear;
  logic cmd_newline;
  logic disp_active;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [CODE_W-1:0] ram_data;
  logic ram_wren;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic busy;
  modport master (
    output wr_valid, wr_code, cmd_clear, cmd_newline, disp_active, disp_addr,
    input wr_ready, ram_addr, ram_data, ram_wren, cursor_col, cursor_row, busy
  );
  modport slave (
    input wr_valid, wr_code, cmd_clear, cmd_newline, disp_active, disp_addr,
    output wr_ready, ram_addr, ram_data, ram_wren, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: cursor-driven character RAM writer sharing the port with display reads; TEXTBUF_CLEAR_ON_RESET_EN wipes the screen after reset
module text_buffer_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int ADDR_W = 13,
  parameter int CODE_W = 5
) (
  input logic clk,
  input logic rst,
  text_buffer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS * ROWS - 1);
`ifdef TEXTBUF_CLEAR_ON_RESET_EN
  localparam logic [1:0] RST_STATE = CLEAR;
`else
  localparam logic [1:0] RST_STATE = IDLE;
`endif
  logic [1:0] state;
  logic [6:0] col;
  logic [5:0] row;
  logic clr_pend;
  logic nl_pend;
  logic [CODE_W-1:0] code_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] clr_addr;
  logic [5:0] row_inc;
  logic [ADDR_W-1:0] cur_addr;
  logic ram_free;
  // cursor arithmetic and RAM port mux; the display read always owns the port when active
  always_comb begin
    row_inc = row == ROW_LAST ? '0 : row + 6'd1;
    cur_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    ram_free = !bus.disp_active;
    bus.wr_ready = state == IDLE && !clr_pend && !nl_pend;
    bus.ram_wren = ram_free && (state == WRITE || state == CLEAR);
    bus.ram_addr = bus.disp_active ? bus.disp_addr : state == CLEAR ? clr_addr : wr_addr;
    bus.ram_data = state == CLEAR ? '0 : code_q;
    bus.busy = state == CLEAR;
    bus.cursor_col = col;
    bus.cursor_row = row;
  end
  // command latching, write/clear sequencing and cursor movement
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      col <= '0;
      row <= '0;
      clr_pend <= 1'b0;
      nl_pend <= 1'b0;
      code_q <= '0;
      wr_addr <= '0;
      clr_addr <= '0;
    end else begin
      clr_pend <= bus.cmd_clear || (clr_pend && state != IDLE);
      nl_pend <= bus.cmd_newline || (nl_pend && !(state == IDLE && !clr_pend));
      case (state)
        IDLE: begin
          if (clr_pend) begin
            state <= CLEAR;
            clr_addr <= '0;
          end else if (nl_pend) begin
            col <= '0;
            row <= row_inc;
          end else if (bus.wr_valid) begin
            code_q <= bus.wr_code;
            wr_addr <= cur_addr;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (ram_free) begin
            state <= IDLE;
            col <= col == COL_LAST ? '0 : col + 7'd1;
            row <= col == COL_LAST ? row_inc : row;
          end
        end
        CLEAR: begin
          if (ram_free) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == CELL_LAST) begin
              state <= IDLE;
              col <= '0;
              row <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: scoreboard bench comparing RAM writes and cursor against a screen-level cursor model
module tb_text_buffer_ctrl;
  logic clk;
  logic rst;
  int vecs = 0;
  int errs = 0;
  int disp_mode = 0;
  int mcol = 0;
  int mrow = 0;
  int exp_q[$];
  text_buffer_if bus ();
  text_buffer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    bus.disp_active = 1'b0;
    bus.disp_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.disp_active = disp_mode == 2 ? 1'b1 : disp_mode == 1 ? ($urandom % 4 == 0) : 1'b0;
      bus.disp_addr = 13'($urandom);
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.disp_active) begin
        chk("disp_addr_pass", int'(bus.ram_addr), int'(bus.disp_addr));
        chk("disp_no_wren", int'(bus.ram_wren), 0);
      end else if (bus.ram_wren) begin
        if (exp_q.size() == 0) chk("spurious_wren", int'(bus.ram_addr), -1);
        else begin
          int e;
          e = exp_q.pop_front();
          chk("ram_addr", int'(bus.ram_addr), e >> 5);
          chk("ram_data", int'(bus.ram_data), e & 31);
        end
      end
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic void model_write(input int code);
    exp_q.push_back(((mrow * 80 + mcol) << 5) | code);
    if (mcol == 79) begin
      mcol = 0;
      mrow = (mrow + 1) % 60;
    end else mcol++;
  endfunction
  function automatic void model_nl();
    mcol = 0;
    mrow = (mrow + 1) % 60;
  endfunction
  task automatic wait_ready(input int limit);
    int n = 0;
    while (!bus.wr_ready && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_timeout", int'(bus.wr_ready), 1);
  endtask
  task automatic chk_cursor();
    chk("cursor_col", int'(bus.cursor_col), mcol);
    chk("cursor_row", int'(bus.cursor_row), mrow);
  endtask
  task automatic do_write(input int code, input bit nl);
    wait_ready(200);
    bus.wr_valid = 1'b1;
    bus.wr_code = 5'(code);
    bus.cmd_newline = nl;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.cmd_newline = 1'b0;
    model_write(code);
    if (nl) model_nl();
    @(negedge clk);
    if (!bus.disp_active) chk("write_latency", int'(bus.ram_wren), 1);
    @(posedge clk);
    #1;
    wait_ready(200);
    chk_cursor();
  endtask
  task automatic do_nl();
    wait_ready(200);
    bus.cmd_newline = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_newline = 1'b0;
    model_nl();
    chk("nl_not_ready", int'(bus.wr_ready), 0);
    wait_ready(200);
    chk_cursor();
  endtask
  task automatic push_clear();
    for (int i = 0; i < 4800; i++) exp_q.push_back(i << 5);
  endtask
  task automatic do_clear(input bit nl, input bit again);
    wait_ready(200);
    bus.cmd_clear = 1'b1;
    bus.cmd_newline = nl;
    @(posedge clk);
    #1;
    bus.cmd_clear = 1'b0;
    bus.cmd_newline = 1'b0;
    push_clear();
    mcol = 0;
    mrow = 0;
    if (nl) model_nl();
    @(posedge clk);
    #1;
    chk("clear_busy", int'(bus.busy), 1);
    chk("clear_not_ready", int'(bus.wr_ready), 0);
    if (again) begin
      repeat (50) @(posedge clk);
      #1;
      bus.cmd_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_clear = 1'b0;
      push_clear();
    end
    wait_ready(40000);
    chk("clear_done_busy", int'(bus.busy), 0);
    chk("clear_drained", exp_q.size(), 0);
    chk_cursor();
  endtask
  task automatic goto(input int c, input int r);
    if (mrow == r && mcol > c) do_nl();
    while (mrow != r) do_nl();
    while (mcol != c) do_write(int'($urandom % 32), 1'b0);
  endtask
  initial begin
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_code = '0;
    bus.cmd_clear = 1'b0;
    bus.cmd_newline = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", int'(bus.wr_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wren", int'(bus.ram_wren), 0);
    chk("rst_addr", int'(bus.ram_addr), 0);
    chk("rst_data", int'(bus.ram_data), 0);
    chk_cursor();
    do_write(1, 1'b0);
    goto(79, 0);
    do_write(2, 1'b0);
    do_write(3, 1'b0);
    wait_ready(200);
    disp_mode = 2;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b1;
    bus.wr_code = 5'd7;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    model_write(7);
    repeat (10) begin
      @(negedge clk);
      chk("stall_wren", int'(bus.ram_wren), 0);
      chk("stall_addr", int'(bus.ram_addr), int'(bus.disp_addr));
    end
    @(posedge clk);
    #1;
    disp_mode = 0;
    @(negedge clk);
    chk("stall_release", int'(bus.ram_wren), 1);
    @(posedge clk);
    #1;
    wait_ready(200);
    chk_cursor();
    goto(79, 59);
    do_write(28, 1'b0);
    goto(5, 3);
    do_clear(1'b0, 1'b1);
    goto(5, 3);
    do_write(9, 1'b1);
    goto(5, 3);
    do_clear(1'b1, 1'b0);
    disp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom % 100);
      if (i == 75) do_clear(1'b0, 1'b0);
      else if (r < 70) do_write(int'($urandom % 32), 1'b0);
      else if (r < 80) do_write(int'($urandom % 32), 1'b1);
      else do_nl();
    end
    disp_mode = 0;
    wait_ready(200);
    bus.cmd_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_clear = 1'b0;
    push_clear();
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    repeat (20) begin
      @(negedge clk);
      chk("post_reset_wren", int'(bus.ram_wren), 0);
    end
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_ready", int'(bus.wr_ready), 1);
    chk_cursor();
    chk("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
